// File: rtl/em_counter_n_if.sv
// Control/data bundle for em_counter_n: synchronous controls and load value
// in, registered count and combinational ripple carry/borrow out.
interface em_counter_n_if #(
    parameter int unsigned WIDTH = 4
);
    logic             nsclr;
    logic             nload;
    logic             ent;
    logic             enp;
    logic             up;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] count;
    logic             rco;

    // Side that drives the controls and observes the count
    modport master (
        output nsclr, nload, ent, enp, up, parallel_in,
        input  count, rco
    );

    // Counter side
    modport slave (
        input  nsclr, nload, ent, enp, up, parallel_in,
        output count, rco
    );
endinterface

// File: rtl/em_counter_n.sv
// Parametrised up/down counter with async clear, sync clear, parallel load,
// T/P enables and direction-aware ripple carry/borrow for cascading.
// Counting runs 0..MODULUS-1; loaded values are kept verbatim.
module em_counter_n #(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input logic           clk,
    input logic           nclr,
    em_counter_n_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "em_counter_n: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "em_counter_n: MODULUS must be in 2..2**WIDTH");
    end

    // Terminal value held at WIDTH bits so MODULUS = 2**WIDTH needs no extra bit
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_last;
    logic             at_zero;

    assign at_last = (count_q == LAST);
    assign at_zero = (count_q == '0);

    // Next-count selection: clear, then load, then enabled step, else hold
    always_comb begin
        count_d = count_q;
        if (!bus.nsclr) begin
            count_d = '0;
        end else if (!bus.nload) begin
            count_d = bus.parallel_in;
        end else if (bus.ent && bus.enp) begin
            if (bus.up) begin
                // >= so out-of-range loaded values return to zero on the next up step
                count_d = (count_q >= LAST) ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = at_zero ? LAST : count_q - WIDTH'(1);
            end
        end
    end

    // Count register with asynchronous active-low clear
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;
    // Exact terminal match only, gated by ent, following the current direction
    assign bus.rco   = bus.ent & (bus.up ? at_last : at_zero);

endmodule
